// File: rtl/uart_cmd_pkg.sv
// Shared constants and types for the UART command parser.
// Sync byte, command codes, FSM states and o_err bit positions.
package uart_cmd_pkg;

    localparam logic [7:0] SYNC_BYTE  = 8'hA5;
    localparam logic [7:0] CMD_WRITE  = 8'h01;
    localparam logic [7:0] CMD_BRIGHT = 8'h02;
    localparam logic [7:0] CMD_CLEAR  = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_HI,
        ST_ADDR_LO,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_DRAIN
    } state_t;

    localparam int ERR_CHK     = 0;
    localparam int ERR_LEN     = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVERRUN = 3;

    function automatic logic cmd_known(input logic [7:0] c);
        return c == CMD_WRITE || c == CMD_BRIGHT || c == CMD_CLEAR;
    endfunction

endpackage

// File: rtl/cmd_payload_buf.sv
// Payload buffer: one write port, one registered read port.
// The read register holds its value unless rd_en is set.
module cmd_payload_buf #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else if (rd_en) rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/uart_cmd_parser.sv
// Frames UART command packets, verifies the XOR checksum and commits
// buffered payloads to the frame buffer or control outputs.
module uart_cmd_parser
    import uart_cmd_pkg::*;
#(
    parameter int ADDR_WIDTH    = 12,
    parameter int MAX_PAYLOAD   = 64,
    parameter int TIMEOUT_TICKS = 4096
) (
    input  logic                  i_clk,
    input  logic                  reset_n,
    input  logic [7:0]            i_rxdata,
    input  logic                  i_rxvalid,
    output logic                  o_wr_valid,
    input  logic                  i_wr_ready,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic [7:0]            o_wr_data,
    output logic [7:0]            o_brightness,
    output logic                  o_clear,
    output logic                  o_pkt_ok,
    output logic [3:0]            o_err,
    output logic                  o_busy
);

    localparam int IW = $clog2(MAX_PAYLOAD);
    localparam int TW = $clog2(TIMEOUT_TICKS);
    localparam logic [TW-1:0] GAP_MAX = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] GAP_ONE = TW'(1);
    localparam logic [IW:0]   IDX_ONE = (IW + 1)'(1);

    state_t                state;
    logic [7:0]            cmd;
    logic [7:0]            len;
    logic [7:0]            addr_hi;
    logic [7:0]            sum;
    logic [7:0]            pay0;
    logic [ADDR_WIDTH-1:0] base;
    logic [IW:0]           idx;
    logic [TW-1:0]         gap;
    logic                  timing;
    logic                  timeout;
    logic                  len_bad;
    logic                  more;
    logic                  fire;
    logic                  rd_en;
    logic                  buf_we;

    assign o_busy  = state != ST_IDLE;
    assign timing  = o_busy && state != ST_DRAIN;
    assign timeout = timing && !i_rxvalid && gap == GAP_MAX;
    assign len_bad = int'(i_rxdata) > MAX_PAYLOAD
                  || (cmd == CMD_BRIGHT && i_rxdata != 8'd1)
                  || (cmd == CMD_CLEAR && i_rxdata != 8'd0);
    assign more    = int'(idx) < int'(len);
    assign fire    = o_wr_valid && i_wr_ready;
    // Fetch the next entry only when the output slot is empty or draining.
    assign rd_en   = state == ST_DRAIN && more && (!o_wr_valid || fire);
    assign buf_we  = state == ST_PAYLOAD && i_rxvalid;

    cmd_payload_buf #(
        .DEPTH (MAX_PAYLOAD)
    ) u_buf (
        .clk     (i_clk),
        .rst_n   (reset_n),
        .wr_en   (buf_we),
        .wr_addr (idx[IW-1:0]),
        .wr_data (i_rxdata),
        .rd_en   (rd_en),
        .rd_addr (idx[IW-1:0]),
        .rd_data (o_wr_data)
    );

    always_ff @(posedge i_clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            cmd          <= '0;
            len          <= '0;
            addr_hi      <= '0;
            sum          <= '0;
            pay0         <= '0;
            base         <= '0;
            idx          <= '0;
            gap          <= '0;
            o_wr_valid   <= 1'b0;
            o_wr_addr    <= '0;
            o_brightness <= 8'hFF;
            o_clear      <= 1'b0;
            o_pkt_ok     <= 1'b0;
            o_err        <= '0;
        end else begin
            o_clear  <= 1'b0;
            o_pkt_ok <= 1'b0;
            o_err    <= '0;
            gap      <= (timing && !i_rxvalid) ? gap + GAP_ONE : '0;
            if (timeout) begin
                o_err[ERR_TIMEOUT] <= 1'b1;
                state              <= ST_IDLE;
            end else if (state == ST_DRAIN) begin
                if (i_rxvalid) o_err[ERR_OVERRUN] <= 1'b1;
                if (rd_en) begin
                    idx        <= idx + IDX_ONE;
                    o_wr_valid <= 1'b1;
                    o_wr_addr  <= base + ADDR_WIDTH'(idx);
                end else if (fire) begin
                    o_wr_valid <= 1'b0;
                    o_pkt_ok   <= 1'b1;
                    state      <= ST_IDLE;
                end
            end else if (i_rxvalid) begin
                sum <= sum ^ i_rxdata;
                unique case (state)
                    ST_IDLE: begin
                        if (i_rxdata == SYNC_BYTE) begin
                            sum   <= '0;
                            state <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        cmd   <= i_rxdata;
                        state <= ST_ADDR_HI;
                    end
                    ST_ADDR_HI: begin
                        addr_hi <= i_rxdata;
                        state   <= ST_ADDR_LO;
                    end
                    ST_ADDR_LO: begin
                        base  <= ADDR_WIDTH'({addr_hi, i_rxdata});
                        state <= ST_LEN;
                    end
                    ST_LEN: begin
                        len <= i_rxdata;
                        idx <= '0;
                        if (len_bad) begin
                            o_err[ERR_LEN] <= 1'b1;
                            state          <= ST_IDLE;
                        end else if (i_rxdata == 8'd0) begin
                            state <= ST_CHK;
                        end else begin
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (idx == '0) pay0 <= i_rxdata;
                        idx <= idx + IDX_ONE;
                        if (int'(idx) == int'(len) - 1) state <= ST_CHK;
                    end
                    ST_CHK: begin
                        idx   <= '0;
                        state <= ST_IDLE;
                        if (i_rxdata != sum || !cmd_known(cmd)) begin
                            o_err[ERR_CHK] <= 1'b1;
                        end else begin
                            unique case (1'b1)
                                cmd == CMD_BRIGHT: begin
                                    o_brightness <= pay0;
                                    o_pkt_ok     <= 1'b1;
                                end
                                cmd == CMD_CLEAR: begin
                                    o_clear  <= 1'b1;
                                    o_pkt_ok <= 1'b1;
                                end
                                default: begin
                                    if (len == '0) o_pkt_ok <= 1'b1;
                                    else state <= ST_DRAIN;
                                end
                            endcase
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule
